// File: rtl/alu_pkg.sv
// Shared encodings for the ALU, the condition-code register and the sharing sequencer.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Bit positions inside the {ZF,SF,OF} register.
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU: add, sub (num1-num2), and, xor with signed overflow flag.
module alu import alu_pkg::*; #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  input  logic [1:0]   operation,
  output logic [W-1:0] result,
  output logic         overflow_flag
);

  always_comb begin
    result        = '0;
    overflow_flag = 1'b0;
    unique case (operation)
      OP_ADD: begin
        result        = num1 + num2;
        overflow_flag = (num1[W-1] == num2[W-1]) && (result[W-1] != num1[W-1]);
      end
      OP_SUB: begin
        result        = num1 - num2;
        overflow_flag = (num1[W-1] != num2[W-1]) && (result[W-1] != num1[W-1]);
      end
      OP_AND: result = num1 & num2;
      OP_XOR: result = num1 ^ num2;
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser whenever update is pulsed.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (valid[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (valid[~ptr_q]) begin
      grant[~ptr_q] = 1'b1;
    end
  end

  // Granting requester 0 hands priority to requester 1, and vice versa.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (update) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU between two requesters; owns the {ZF,SF,OF} register.
// Optional ALU_SHARE_PERF_EN adds saturating per-requester op counters and a stall counter.
module alu_share_ctrl import alu_pkg::*; #(
  parameter int unsigned W        = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [3:0]     req_op,
  input  logic [1:0]     req_set_cc,
  output logic           resp_valid,
  output logic           resp_id,
  output logic [W-1:0]   resp_result,
  output logic           resp_ovf,
  input  logic           resp_ready,
  output logic [2:0]     cc
`ifdef ALU_SHARE_PERF_EN
  ,
  output logic [31:0]    perf_ops0,
  output logic [31:0]    perf_ops1,
  output logic [31:0]    perf_stall
`endif
);

  state_e         state_q, state_d;
  logic [1:0]     grant;
  logic           accept;
  logic           sel;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic           set_cc_q, id_q;
  logic [W-1:0]   alu_res;
  logic           alu_ovf;
  logic [W-1:0]   result_q;
  logic           ovf_q, rid_q;
  logic [2:0]     cc_q;

  assign accept = (state_q == StIdle) && (grant != 2'b00);
  assign sel    = grant[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req_valid),
    .update  (accept),
    .grant   (grant)
  );

  alu #(.W(W)) u_alu (
    .num1          (a_q),
    .num2          (b_q),
    .operation     (op_q),
    .result        (alu_res),
    .overflow_flag (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      set_cc_q <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rid_q    <= 1'b0;
      cc_q     <= CC_RESET;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= sel ? req_a[2*W-1:W] : req_a[W-1:0];
        b_q      <= sel ? req_b[2*W-1:W] : req_b[W-1:0];
        op_q     <= sel ? req_op[3:2] : req_op[1:0];
        set_cc_q <= req_set_cc[sel];
        id_q     <= sel;
      end
      if (state_q == StExec) begin
        result_q <= alu_res;
        ovf_q    <= alu_ovf;
        rid_q    <= id_q;
        if (set_cc_q) begin
          cc_q[CC_ZF] <= (alu_res == '0);
          cc_q[CC_SF] <= alu_res[W-1];
          cc_q[CC_OF] <= alu_ovf;
        end
      end
    end
  end

  assign req_ready   = (state_q == StIdle) ? grant : 2'b00;
  assign resp_valid  = (state_q == StResp);
  assign resp_id     = rid_q;
  assign resp_result = result_q;
  assign resp_ovf    = ovf_q;
  assign cc          = cc_q;

`ifdef ALU_SHARE_PERF_EN
  logic [31:0] ops0_q, ops1_q, stall_q;
  logic        hs;

  assign hs = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops0_q  <= '0;
      ops1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (hs && !rid_q && (ops0_q != '1)) ops0_q <= ops0_q + 32'd1;
      if (hs && rid_q && (ops1_q != '1)) ops1_q <= ops1_q + 32'd1;
      if (((req_valid & ~req_ready) != 2'b00) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops0  = ops0_q;
  assign perf_ops1  = ops1_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a transaction-level reference model checked every cycle.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [3:0]     req_op;
  logic [1:0]     req_set_cc;
  logic           resp_valid, resp_id, resp_ready, resp_ovf;
  logic [W-1:0]   resp_result;
  logic [2:0]     cc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc[$];
  int acc_id[$];
  int last_hs = -1;

  alu_share_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_set_cc  (req_set_cc),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_ovf    (resp_ovf),
    .resp_ready  (resp_ready),
    .cc          (cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding op, aged 1 while executing and 2 while the response waits.
  logic         m_have;
  int           m_age;
  logic         m_ptr;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_op;
  logic         m_setcc, m_id;
  logic [W-1:0] e_result;
  logic         e_ovf, e_id;
  logic [2:0]   e_cc;

  function automatic logic [1:0] m_winner(input logic [1:0] v, input logic p);
    logic [1:0] one;
    one = 2'b01;
    if (v[p]) return one << p;
    if (v[!p]) return one << !p;
    return 2'b00;
  endfunction

  // Returns {overflow, result}; overflow means the exact signed value does not fit in W bits.
  function automatic logic [W:0] m_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] op);
    logic signed [W:0] s;
    case (op)
      OP_ADD: begin
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        return {s[W] ^ s[W-1], s[W-1:0]};
      end
      OP_SUB: begin
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        return {s[W] ^ s[W-1], s[W-1:0]};
      end
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [1:0] w;
    logic [W:0] r;
    if (!reset_n) begin
      m_have   <= 1'b0;
      m_age    <= 0;
      m_ptr    <= 1'b0;
      e_result <= '0;
      e_ovf    <= 1'b0;
      e_id     <= 1'b0;
      e_cc     <= 3'b100;
    end else if (!m_have) begin
      w = m_winner(req_valid, m_ptr);
      if (w != 2'b00) begin
        m_id    <= w[1];
        m_a     <= w[1] ? req_a[2*W-1:W] : req_a[W-1:0];
        m_b     <= w[1] ? req_b[2*W-1:W] : req_b[W-1:0];
        m_op    <= w[1] ? req_op[3:2] : req_op[1:0];
        m_setcc <= req_set_cc[w[1]];
        m_have  <= 1'b1;
        m_age   <= 1;
        m_ptr   <= !w[1];
      end
    end else if (m_age == 1) begin
      r = m_alu(m_a, m_b, m_op);
      e_result <= r[W-1:0];
      e_ovf    <= r[W];
      e_id     <= m_id;
      if (m_setcc) e_cc <= {r[W-1:0] == '0, r[W-1], r[W]};
      m_age <= 2;
    end else if (resp_ready) begin
      m_have <= 1'b0;
      m_age  <= 0;
    end
  end

  // Single compare process, sampling 4 time units after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #4;
      chk("req_ready", req_ready, m_have ? 2'b00 : m_winner(req_valid, m_ptr));
      chk("resp_valid", resp_valid, m_have && (m_age == 2));
      chk("resp_id", resp_id, e_id);
      chk("resp_result", resp_result, e_result);
      chk("resp_ovf", resp_ovf, e_ovf);
      chk("cc", cc, e_cc);
      if ((req_valid & req_ready) != 2'b00) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(int'(req_ready[1]));
      end
      if (resp_valid && resp_ready) last_hs = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic sc);
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
    req_op[id*2 +: 2] = op;
    req_set_cc[id]    = sc;
    req_valid[id]     = 1'b1;
  endtask

  // Called at +2; returns at +2 of the cycle after the accept edge with valid dropped.
  task automatic wait_accept(input int id, input int n);
    bit got = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (req_valid[id] && req_ready[id]) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    req_valid[id] = 1'b0;
  endtask

  // Called at +2; returns at +3 of the first cycle with resp_valid, k = cycles waited.
  task automatic wait_resp(input int n, output int k);
    bit got = 0;
    for (k = 0; k < n; k++) begin
      #1;
      if (resp_valid) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int base;
    reset_n    = 1'b0;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    req_set_cc = 2'b00;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cc", cc, 3'b100);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 2'b00);
    reset_n = 1'b1;
    tick();

    // Signed overflow on requester 1, cc untouched.
    set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0);
    wait_accept(1, 5);
    chk("exec_no_valid", resp_valid, 0);
    wait_resp(5, k);
    chk("latency", k, 1);
    chk("ovf_result", resp_result, 64'h8000_0000_0000_0000);
    chk("ovf_flag", resp_ovf, 1);
    chk("ovf_id", resp_id, 1);
    chk("ovf_cc", cc, 3'b100);
    chk("model_ovf", e_result, 64'h8000_0000_0000_0000);
    tick();

    set_req(0, -64'sd5, 64'd107, OP_ADD, 1'b1);
    wait_accept(0, 5);
    wait_resp(5, k);
    chk("add_result", resp_result, 64'd102);
    chk("add_ovf", resp_ovf, 0);
    chk("add_id", resp_id, 0);
    chk("add_cc", cc, 3'b000);
    chk("model_add", e_result, 64'd102);
    tick();

    set_req(0, 64'h00FF, 64'hFF00, OP_AND, 1'b1);
    wait_accept(0, 5);
    wait_resp(5, k);
    chk("and_result", resp_result, 64'd0);
    chk("and_cc", cc, 3'b100);
    tick();

    set_req(0, 64'h00FF, 64'hFF00, OP_XOR, 1'b1);
    wait_accept(0, 5);
    wait_resp(5, k);
    chk("xor_result", resp_result, 64'hFFFF);
    chk("xor_cc", cc, 3'b000);
    chk("model_xor_cc", e_cc, 3'b000);
    tick();

    // Idle reset pulse returns the pointer to requester 0.
    reset_n = 1'b0;
    tick();
    chk("idle_rst_cc", cc, 3'b100);
    reset_n = 1'b1;
    tick();

    // Both requesters continuously valid: grants alternate, 3 cycles apart.
    base = acc_cyc.size();
    set_req(0, 64'd10, 64'd3, OP_SUB, 1'b1);
    set_req(1, 64'd1, 64'd2, OP_ADD, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (acc_cyc.size() >= base + 4) break;
    end
    req_valid = 2'b00;
    chk("rr_count", acc_cyc.size() - base, 4);
    if (acc_cyc.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant", acc_id[base+i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", acc_cyc[base+i] - acc_cyc[base+i-1], 3);
    end
    repeat (3) tick();

    // Back-pressure: response held, second requester pending.
    resp_ready = 1'b0;
    set_req(0, 64'd7, 64'd8, OP_ADD, 1'b1);
    set_req(1, 64'd100, 64'd1, OP_SUB, 1'b1);
    wait_accept(0, 5);
    wait_resp(5, k);
    repeat (5) tick();
    chk("hold_result", resp_result, 64'd15);
    chk("hold_valid", resp_valid, 1);
    chk("hold_ready", req_ready, 2'b00);
    resp_ready = 1'b1;
    wait_accept(1, 5);
    chk("accept_after_hs", acc_cyc[$] - last_hs, 1);
    wait_resp(5, k);
    chk("sub_result", resp_result, 64'd99);
    chk("sub_cc", cc, 3'b000);
    tick();

    // Reset during EXEC discards the op.
    set_req(0, 64'd3, 64'd5, OP_SUB, 1'b1);
    wait_accept(0, 5);
    reset_n = 1'b0;
    tick();
    chk("midrst_cc", cc, 3'b100);
    chk("midrst_valid", resp_valid, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_resp", resp_valid, 0);
    end
    set_req(1, 64'd1, 64'd2, OP_ADD, 1'b0);
    #1;
    chk("ready_reassert", req_ready, 2'b10);
    #1;
    wait_accept(1, 5);
    wait_resp(5, k);
    chk("final_result", resp_result, 64'd3);
    chk("final_cc", cc, 3'b100);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
